// File: rtl/rotseq_pkg.sv
// Shared types and constants for the multi-pass rotate sequencer.
// Imported by the sequencer top and its rotator stage.
package rotseq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        DONE
    } rotseq_state_t;

    localparam int MAX_STEP = 7;

endpackage

// File: rtl/rot_step.sv
// Single-pass left rotator: up to 7 positions per pass.
// Three conditional stages of 1, 2 and 4 bits.
module rot_step
    import rotseq_pkg::*;
#(
    parameter  int N     = 4,
    localparam int WIDTH = 2 ** N
) (
    input  logic [WIDTH-1:0] d,
    input  logic [2:0]       amt,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    assign s1 = amt[0] ? {d[WIDTH-2:0], d[WIDTH-1]} : d;
    assign s2 = amt[1] ? {s1[WIDTH-3:0], s1[WIDTH-1 -: 2]} : s1;
    assign q  = amt[2] ? {s2[WIDTH-5:0], s2[WIDTH-1 -: 4]} : s2;

endmodule

// File: rtl/rotate_sequencer.sv
// Multi-pass left-rotate engine: repeats a 7-position rotator pass
// until the full rotate amount has been applied.
module rotate_sequencer
    import rotseq_pkg::*;
#(
    parameter  int N     = 4,
    localparam int WIDTH = 2 ** N
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [N-1:0]     in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    rotseq_state_t    state;
    rotseq_state_t    nxt;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] rotated;
    logic [N-1:0]     remaining;
    logic [N-1:0]     rem_nxt;
    logic [2:0]       step;
    logic             accept;

    assign accept = in_valid && in_ready;

    // step <= remaining by construction, so remaining never underflows
    always_comb begin
        step = remaining[2:0];
        if (remaining > N'(MAX_STEP)) begin
            step = 3'(MAX_STEP);
        end
        rem_nxt = remaining - N'(step);
    end

    rot_step #(
        .N(N)
    ) u_rot_step (
        .d  (data),
        .amt(step),
        .q  (rotated)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    nxt = (in_amt == '0) ? DONE : ROTATE;
                end
            end
            ROTATE: begin
                if (rem_nxt == '0) begin
                    nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            data      <= '0;
            remaining <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= nxt;
            in_ready  <= (nxt == IDLE);
            out_valid <= (nxt == DONE);
            busy      <= (nxt != IDLE);
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        data      <= in_data;
                        remaining <= in_amt;
                    end
                end
                ROTATE: begin
                    data      <= rotated;
                    remaining <= rem_nxt;
                end
                default: ;
            endcase
        end
    end

    assign out_data = data;

endmodule

// File: doc/rotate_sequencer.md
Name: rotate_sequencer

Overview:
- Multi-pass left-rotate engine for 2**N-bit words where the rotate amount is N bits wide and can exceed 7.
- The datapath rotator stage handles at most 7 positions per pass (3-bit amount). This block sequences repeated passes through that stage until the full amount has been applied.
- Sits between a producer and a consumer, with valid/ready handshakes on both sides.
- Used wherever word widths of 16 bits or more need arbitrary rotation without a wide single-cycle rotator.

Parameters:
- N, default 4: log2 of data width. Data width WIDTH = 2**N. Legal N >= 3.
- WIDTH (localparam) = 2**N.
- MAX_STEP (localparam) = 7: largest rotation one pass can apply.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a request on in_data/in_amt.
- in_ready  output  1  block can accept a request this cycle.
- in_data  input  WIDTH  word to rotate.
- in_amt  input  N  total left-rotate amount, 0..WIDTH-1.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  WIDTH  rotated word, registered.
- busy  output  1  a request is held (state is ROTATE or DONE).

Behaviour:
- Interface: one clock (clk); reset_n is asynchronous and active-low.
- Reset while reset_n = 0:
  - state = IDLE
  - data register = 0, remaining = 0
  - out_valid = 0, busy = 0, in_ready = 0
- in_ready is registered. It rises on the first clk edge after reset_n deasserts, and thereafter equals (next state == IDLE).
- States:
  - IDLE: in_ready = 1. On in_valid && in_ready (cycle T), latch data <= in_data and remaining <= in_amt.
    - If in_amt == 0, go to DONE.
    - Otherwise go to ROTATE.
  - ROTATE: each cycle:
    - step = min(remaining, 7)
    - data <= rotl(data, step)
    - remaining <= remaining - step
    - If remaining - step == 0, go to DONE; otherwise stay in ROTATE.
  - DONE: out_valid = 1 and out_data = data. Hold both stable while out_ready = 0. On out_ready = 1, go to IDLE; out_valid falls the next cycle.
- Latency: passes P = ceil(in_amt/7), with P = 0 for in_amt = 0. out_valid is first high in cycle T+P+1.
- Throughput: in_ready = 0 during ROTATE and DONE. There is no accept in the same cycle as the output handshake, so back-to-back requests incur one IDLE cycle.
- Rotation is circular modulo WIDTH: bit i moves to bit (i+step) mod WIDTH, and no bits are lost.
- remaining is N bits wide and never underflows, because step <= remaining by construction.
- in_data and in_amt are ignored when in_ready = 0. Once a request is accepted, the block does not sample them again.
- out_valid must not be asserted in IDLE or ROTATE.
- busy = 1 exactly in ROTATE and DONE.
- reset_n asserted mid-ROTATE or in DONE: immediate return to reset values. The held request is discarded and no out_valid pulse is produced.

Decomposition:
- Shared package rotseq_pkg:
  - typedef enum logic [1:0] {IDLE, ROTATE, DONE} rotseq_state_t
  - localparam MAX_STEP = 7
- One sub-module, rot_step: combinational left rotate of WIDTH bits by a 3-bit amount, built as three conditional stages of 1, 2 and 4 bits.
  - Parameter N.
  - Instantiated once, driven by the data register and step.
- The FSM, remaining counter and handshake logic stay in rotate_sequencer.

Test Plan (N=4, WIDTH=16; T = accept cycle):
- Reset release: reset_n low for 3 cycles, then high -> in_ready = 0, out_valid = 0 and busy = 0 during reset; in_ready = 1 from the first edge after release.
- Single pass: in_data = 0x8001, in_amt = 1 -> out_data = 0x0003, out_valid high at T+2. Also in_amt = 7, in_data = 0x00FF -> 0x7F80 at T+2.
- Multi-pass: in_amt = 14, in_data = 0x1234 -> passes of 7, 7; out_data = 0x048D at T+3. Then in_amt = 15, in_data = 0x0001 -> passes of 7, 7, 1; out_data = 0x8000 at T+4.
- Zero amount: in_amt = 0, in_data = 0xBEEF -> out_data = 0xBEEF, out_valid at T+1, busy high for exactly the DONE cycles.
- Backpressure and back-to-back: hold out_ready = 0 for 5 cycles with in_valid held high.
  - out_data stays stable and in_ready = 0.
  - After out_ready pulses, out_valid drops next cycle, in_ready = 1, and the second request is accepted the cycle after that.
- Reset mid-operation: accept in_amt = 15, then assert reset_n low at T+2 -> out_valid never rises, state = IDLE, out_data = 0. A fresh request with in_amt = 3, in_data = 0x0001 then yields 0x0008.
